// File: rtl/sram_stream_fifo.sv
// Stream FIFO backed by a single-port, latency-1 SRAM plus a two-entry output buffer.
// Reads and writes share the SRAM port under a last-grant arbiter; optional fall-through bypass.

module tc_sram_impl #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 1,
  parameter int unsigned Latency   = 1,
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPorts-1:0]                  req_i,
  input  logic [NumPorts-1:0]                  we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]     be_i,
  output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
);

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [NumPorts-1:0][DataWidth-1:0] wmask;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    for (genvar i = 0; i < DataWidth; i++) begin : g_mask
      assign wmask[p][i] = be_i[p][i / ByteWidth];
    end

    always_ff @(posedge clk_i) begin
      if (req_i[p] && we_i[p]) begin
        mem_q[addr_i[p]] <= (mem_q[addr_i[p]] & ~wmask[p]) | (wdata_i[p] & wmask[p]);
      end
    end

    if (Latency == 1) begin : g_lat1
      logic [DataWidth-1:0] rd_q;
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          rd_q <= '0;
        end else if (req_i[p] && !we_i[p]) begin
          rd_q <= mem_q[addr_i[p]];
        end
      end
      assign rdata_o[p] = rd_q;
    end else begin : g_latn
      logic [Latency-1:0][DataWidth-1:0] pipe_q;
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= {pipe_q[Latency-2:0], pipe_q[0]};
          if (req_i[p] && !we_i[p]) begin
            pipe_q[0] <= mem_q[addr_i[p]];
          end
        end
      end
      assign rdata_o[p] = pipe_q[Latency-1];
    end
  end

endmodule

module sram_stream_fifo #(
  parameter int unsigned NumWords         = 1024,
  parameter int unsigned DataWidth        = 32,
  parameter bit          Bypass           = 1'b1,
  parameter int unsigned AlmostFullThresh = NumWords,
  parameter int unsigned LevelWidth       = $clog2(NumWords + 3)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DataWidth-1:0]  in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DataWidth-1:0]  out_data_o,
  output logic [LevelWidth-1:0] level_o,
  output logic                  almost_full_o,
  output logic                  empty_o
);

  localparam int unsigned AddrWidth = $clog2(NumWords);
  localparam int unsigned CntWidth  = $clog2(NumWords + 1);
  localparam int unsigned BeWidth   = (DataWidth + 7) / 8;

  typedef enum logic {GrantWrite, GrantRead} grant_e;

  logic [AddrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntWidth-1:0]  sram_cnt_q, sram_cnt_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           buf_cnt_q, buf_cnt_d;
  logic                 buf_head_q, buf_head_d;
  logic [DataWidth-1:0] buf_mem_q [2];
  logic [DataWidth-1:0] buf_mem_d [2];
  grant_e               last_grant_q, last_grant_d;

  logic                 sram_empty, sram_full, read_elig, read_prio;
  logic                 bypass_state, bypass_route;
  logic                 push, pop, byp_push, sram_wr, rd_issue;
  logic                 buf_wr, wr_idx;
  logic [1:0]           occ;
  logic [DataWidth-1:0] buf_wdata, sram_rdata;
  logic [LevelWidth-1:0] level;

  assign sram_empty = (sram_cnt_q == '0);
  assign sram_full  = (sram_cnt_q == CntWidth'(NumWords));
  assign occ        = buf_cnt_q + {1'b0, inflight_q};
  assign read_elig  = !sram_empty && (occ < 2'd2);
  assign read_prio  = read_elig && (last_grant_q == GrantWrite);

  // in_ready may only look at state and clear, so the bypass term here ignores same-cycle pops.
  assign bypass_state = Bypass && sram_empty && !inflight_q && (buf_cnt_q != 2'd2);
  assign in_ready_o   = !clear_i && !read_prio && (!sram_full || bypass_state);

  assign out_valid_o = (buf_cnt_q != 2'd0);
  assign out_data_o  = buf_mem_q[buf_head_q];

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // Routing may use the pop: a full buffer that drains this cycle still takes a bypassed word.
  assign bypass_route = Bypass && sram_empty && !inflight_q && ((buf_cnt_q != 2'd2) || pop);
  assign byp_push     = push && bypass_route;
  assign sram_wr      = push && !bypass_route;
  assign rd_issue     = !clear_i && read_elig && !push;

  assign buf_wr    = byp_push || inflight_q;
  assign buf_wdata = inflight_q ? sram_rdata : in_data_i;
  assign wr_idx    = buf_head_q ^ buf_cnt_q[0];

  tc_sram_impl #(
    .NumWords (NumWords),
    .DataWidth(DataWidth),
    .ByteWidth(8),
    .NumPorts (1),
    .Latency  (1)
  ) i_sram (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (sram_wr || rd_issue),
    .we_i   (sram_wr),
    .addr_i (sram_wr ? wptr_q : rptr_q),
    .wdata_i(in_data_i),
    .be_i   ({BeWidth{1'b1}}),
    .rdata_o(sram_rdata)
  );

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    sram_cnt_d   = sram_cnt_q;
    inflight_d   = rd_issue;
    buf_cnt_d    = buf_cnt_q;
    buf_head_d   = buf_head_q ^ pop;
    buf_mem_d    = buf_mem_q;
    last_grant_d = last_grant_q;

    if (sram_wr) begin
      wptr_d = (wptr_q == AddrWidth'(NumWords - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (rd_issue) begin
      rptr_d = (rptr_q == AddrWidth'(NumWords - 1)) ? '0 : rptr_q + 1'b1;
    end

    case ({sram_wr, rd_issue})
      2'b10:   sram_cnt_d = sram_cnt_q + 1'b1;
      2'b01:   sram_cnt_d = sram_cnt_q - 1'b1;
      default: sram_cnt_d = sram_cnt_q;
    endcase

    case ({buf_wr, pop})
      2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
      2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
      default: buf_cnt_d = buf_cnt_q;
    endcase

    if (buf_wr) begin
      buf_mem_d[wr_idx] = buf_wdata;
    end

    if (rd_issue) begin
      last_grant_d = GrantRead;
    end else if (push) begin
      last_grant_d = GrantWrite;
    end

    // Flush drops the in-flight capture too, since inflight_d is forced low.
    if (clear_i) begin
      wptr_d       = '0;
      rptr_d       = '0;
      sram_cnt_d   = '0;
      inflight_d   = 1'b0;
      buf_cnt_d    = 2'd0;
      buf_head_d   = 1'b0;
      last_grant_d = GrantWrite;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      sram_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      buf_cnt_q    <= 2'd0;
      buf_head_q   <= 1'b0;
      last_grant_q <= GrantWrite;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      sram_cnt_q   <= sram_cnt_d;
      inflight_q   <= inflight_d;
      buf_cnt_q    <= buf_cnt_d;
      buf_head_q   <= buf_head_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk_i) begin
    buf_mem_q <= buf_mem_d;
  end

  assign level = LevelWidth'(sram_cnt_q) + LevelWidth'(buf_cnt_q) + LevelWidth'(inflight_q);
  assign level_o       = level;
  assign almost_full_o = (32'(level) >= AlmostFullThresh);
  assign empty_o       = (level == '0);

  a_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && sram_full && !bypass_route));
  a_read_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rd_issue |-> !sram_empty);
  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i && !clear_i) |=> $stable(out_data_o));

endmodule

// File: tb/tb_sram_stream_fifo.sv
// Bench for sram_stream_fifo: one bypass and one non-bypass instance, directed latency/flush
// scenarios plus random traffic, all outputs scored against a per-instance word queue.

module tb_sram_stream_fifo;

  localparam int unsigned NW  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned AFT = 4;
  localparam int unsigned LW  = $clog2(NW + 3);
  localparam int          Cap = NW + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear     [2];
  logic          in_valid  [2];
  logic          out_ready [2];
  logic [DW-1:0] in_data   [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          almost_full [2];
  logic          empty     [2];
  logic [DW-1:0] out_data  [2];
  logic [LW-1:0] level     [2];

  int checks = 0;
  int errors = 0;

  // Reference model: accepted words in order, one circular list per instance.
  logic [DW-1:0] mdl [2][64];
  int            hd  [2];
  int            tl  [2];

  always #5 clk = ~clk;

  sram_stream_fifo #(
    .NumWords(NW), .DataWidth(DW), .Bypass(1'b1), .AlmostFullThresh(AFT), .LevelWidth(LW)
  ) u_byp (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
    .level_o(level[0]), .almost_full_o(almost_full[0]), .empty_o(empty[0])
  );

  sram_stream_fifo #(
    .NumWords(NW), .DataWidth(DW), .Bypass(1'b0), .AlmostFullThresh(AFT), .LevelWidth(LW)
  ) u_nobyp (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
    .level_o(level[1]), .almost_full_o(almost_full[1]), .empty_o(empty[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic monitor();
    int sz;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          hd[d] = 0;
          tl[d] = 0;
        end else begin
          sz = tl[d] - hd[d];
          check($sformatf("level[%0d]", d), 32'(level[d]), sz);
          check($sformatf("empty[%0d]", d), 32'(empty[d]), 32'(sz == 0));
          check($sformatf("almost_full[%0d]", d), 32'(almost_full[d]), 32'(sz >= AFT));
          check($sformatf("capacity[%0d]", d), 32'(sz <= Cap), 1);
          if (clear[d]) begin
            hd[d] = 0;
            tl[d] = 0;
          end else begin
            if (out_valid[d] && out_ready[d]) begin
              if (sz == 0) begin
                check($sformatf("pop_when_model_empty[%0d]", d), 1, 0);
              end else begin
                check($sformatf("data[%0d]", d), 32'(out_data[d]), 32'(mdl[d][hd[d] % 64]));
                hd[d]++;
              end
            end
            if (in_valid[d] && in_ready[d]) begin
              mdl[d][tl[d] % 64] = in_data[d];
              tl[d]++;
            end
          end
        end
      end
    end
  endtask

  task automatic push_one(input int d, input logic [DW-1:0] v);
    int n = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    while (!in_ready[d] && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready[d]) begin
      check($sformatf("push_timeout[%0d]", d), 0, 1);
    end else begin
      tick();
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n = 0;
    out_ready[d] = 1'b1;
    while (level[d] != 0 && n < 60) begin
      tick();
      n++;
    end
    out_ready[d] = 1'b0;
    check($sformatf("drain_done[%0d]", d), 32'(level[d]), 0);
  endtask

  task automatic chk_reset(input int d);
    check($sformatf("rst_in_ready[%0d]", d), 32'(in_ready[d]), 1);
    check($sformatf("rst_out_valid[%0d]", d), 32'(out_valid[d]), 0);
    check($sformatf("rst_level[%0d]", d), 32'(level[d]), 0);
    check($sformatf("rst_empty[%0d]", d), 32'(empty[d]), 1);
    check($sformatf("rst_almost_full[%0d]", d), 32'(almost_full[d]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] nxt;
    logic          prev_rdy;
    int            pushed;
    int            cyc;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clear[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_data[d] = '0;
      hd[d] = 0; tl[d] = 0;
    end
    fork
      monitor();
    join_none
    tick();
    tick();
    rst_n = 1'b1;
    chk_reset(0);
    chk_reset(1);

    // Bypass fall-through: visible one cycle after the push, gone after the pop.
    in_valid[0] = 1'b1; in_data[0] = 8'hA5; out_ready[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    check("byp_valid_t1", 32'(out_valid[0]), 1);
    check("byp_data_t1", 32'(out_data[0]), 32'h A5);
    check("byp_level_t1", 32'(level[0]), 1);
    tick();
    out_ready[0] = 1'b0;
    check("byp_level_t2", 32'(level[0]), 0);
    check("byp_valid_t2", 32'(out_valid[0]), 0);

    // SRAM path without bypass: write, read, capture, then valid.
    in_valid[1] = 1'b1; in_data[1] = 8'h11;
    tick();
    in_valid[1] = 1'b0;
    check("sram_level_t1", 32'(level[1]), 1);
    check("sram_valid_t1", 32'(out_valid[1]), 0);
    tick();
    check("sram_valid_t2", 32'(out_valid[1]), 0);
    check("sram_level_t2", 32'(level[1]), 1);
    tick();
    check("sram_valid_t3", 32'(out_valid[1]), 1);
    check("sram_data_t3", 32'(out_data[1]), 32'h11);
    drain(1);

    // Fill to capacity with the consumer stalled, then drain in order.
    for (int i = 1; i <= Cap; i++) begin
      push_one(0, 8'(i));
      check($sformatf("fill_level_%0d", i), 32'(level[0]), i);
      check($sformatf("fill_af_%0d", i), 32'(almost_full[0]), 32'(i >= AFT));
    end
    check("full_in_ready", 32'(in_ready[0]), 0);
    check("full_out_data", 32'(out_data[0]), 32'h01);
    drain(0);
    check("drained_empty", 32'(empty[0]), 1);

    // Saturated traffic with the SRAM non-empty: the port alternates read and write.
    for (int i = 0; i < 3; i++) push_one(0, 8'(8'h40 + i));
    nxt = 8'h43; pushed = 0; cyc = 0; prev_rdy = 1'b0;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    while (pushed < 100 && cyc < 400) begin
      in_data[0] = nxt;
      if (cyc > 0) check("in_ready_toggle", 32'(in_ready[0]), 32'(!prev_rdy));
      else         check("in_ready_first", 32'(in_ready[0]), 1);
      prev_rdy = in_ready[0];
      if (in_ready[0]) begin
        nxt++;
        pushed++;
      end
      tick();
      cyc++;
    end
    in_valid[0] = 1'b0;
    check("toggle_words", pushed, 100);
    drain(0);

    // Flush with three words held and a read in flight.
    for (int i = 0; i < 4; i++) push_one(1, 8'(8'h90 + i));
    check("pre_clear_level4", 32'(level[1]), 4);
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    tick();
    check("pre_clear_level3", 32'(level[1]), 3);
    clear[1] = 1'b1;
    #1;
    check("clear_in_ready", 32'(in_ready[1]), 0);
    tick();
    clear[1] = 1'b0;
    #1;
    check("post_clear_level", 32'(level[1]), 0);
    check("post_clear_valid", 32'(out_valid[1]), 0);
    check("post_clear_in_ready", 32'(in_ready[1]), 1);
    push_one(1, 8'h77);
    drain(1);

    // Random traffic with sporadic flushes and one mid-stream reset.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
          clear[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
        end
        #1;
        chk_reset(0);
        chk_reset(1);
        push_one(0, 8'h3C);
        check("post_rst_valid", 32'(out_valid[0]), 1);
        check("post_rst_data", 32'(out_data[0]), 32'h3C);
      end
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = ($urandom_range(0, 3) != 0);
        in_data[d]   = 8'($urandom);
        out_ready[d] = ($urandom_range(0, 2) != 0);
        clear[d]     = ($urandom_range(0, 49) == 0);
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; clear[d] = 1'b0; out_ready[d] = 1'b0;
    end
    drain(0);
    drain(1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_stream_fifo.md
SRAM_STREAM_FIFO -- requirements
Module: sram_stream_fifo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NumWords, 1024, SRAM depth in words (>=2)
- DataWidth, 32, word width
- Bypass, 1'b1, enables SRAM fall-through when the SRAM is empty
- AlmostFullThresh, NumWords, level at or above which almost_full_o is high
- LevelWidth, cf_math_pkg::idx_width(NumWords+3), width of level_o
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, the single clock
- rst_ni, in, 1, reset; synchronous, active-low
- clear_i, in, 1, synchronous flush
- in_valid_i, in, 1, input word valid
- in_ready_o, out, 1, input accepted when high together with in_valid_i
- in_data_i, in, DataWidth, input word
- out_valid_o, out, 1, output word valid
- out_ready_i, in, 1, consumer ready
- out_data_o, out, DataWidth, output word, stable while out_valid_o & !out_ready_i
- level_o, out, LevelWidth, total words held (SRAM + read in flight + output buffer)
- almost_full_o, out, 1, level_o >= AlmostFullThresh
- empty_o, out, 1, level_o == 0

Function
REQ-003 Storage SHALL be one tc_sram_impl instance: single port, Latency 1, NumPorts 1, full byte enable; total capacity NumWords+2 (SRAM + 2-entry output buffer).
- REQ-004 Push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i; data order SHALL be strict FIFO.
- REQ-005 SRAM addressing SHALL use write/read pointers wrapping NumWords-1 -> 0; the SRAM word count (sram_cnt) ranges 0..NumWords.
- REQ-006 read_elig (state only) = sram_cnt>0 & (buf_cnt + inflight) < 2, where buf_cnt counts output buffer entries and inflight is 1 in the cycle after a read issue.
- REQ-007 Arbitration SHALL be a 1-bit last-grant register: if read_elig and last grant was WRITE, issue a read and drive in_ready_o=0; otherwise in_ready_o = (sram_cnt<NumWords) | bypass_ok. A read issue sets last grant to READ; a push sets it to WRITE.
- REQ-008 in_ready_o SHALL depend only on registered state and clear_i, never on in_valid_i or out_ready_i.
- REQ-009 A read issue with no push SHALL also occur whenever read_elig holds and in_ready_o is not required for a push, i.e. reads are never withheld when no push occurs.
- REQ-010 Read data SHALL enter the output buffer at the end of the cycle after issue; out_valid_o rises the following cycle.
- REQ-011 bypass_ok (Bypass=1 only) = sram_cnt==0 & inflight==0 & buf_cnt<2, with a pop in the same cycle counting as freeing a slot; a bypassed push SHALL write the buffer directly, with out_valid_o high the next cycle.
- REQ-012 Latency, push at cycle T with empty block SHALL yield out_valid_o at T+1 (bypass) or T+3 (SRAM path: write T, read T+1, capture T+2).
- REQ-013 Simultaneous push and pop SHALL leave level_o unchanged; level_o SHALL never exceed NumWords+2 nor underflow.
- REQ-014 clear_i SHALL force in_ready_o=0 that cycle, ignore any push, discard in-flight read data, reset pointers, counters and last-grant (=WRITE), and give out_valid_o=0 and level_o=0 the next cycle.
- REQ-015 Assertions SHALL flag: push while sram full and bypass not ok; read issue with sram_cnt==0; out_data_o change while stalled.

Reset
REQ-016 With rst_ni low at a clock edge, all state SHALL clear as for clear_i.
REQ-017 Outputs after reset: in_ready_o=1, out_valid_o=0, level_o=0, empty_o=1, almost_full_o=0 (AlmostFullThresh>0).
REQ-018 Reset SHALL override clear_i and any handshake in the same cycle; in-flight SRAM data SHALL be discarded.

Verification (NumWords=4, DataWidth=8, AlmostFullThresh=4)
REQ-019 Bypass=1, push 0xA5 at T, out_ready_i=1 -> out_valid_o=1 with 0xA5 at T+1, level_o back to 0 at T+2.
REQ-020 Bypass=0, push 0x11 at T -> out_valid_o=1 at T+3; level_o=1 from T+1.
REQ-021 out_ready_i=0, push 0x01..0x06 back-to-back -> in_ready_o=0 after level_o=6, almost_full_o=1 at level_o>=4; then drain reads 0x01..0x06 in order across pointer wrap.
REQ-022 Continuous in_valid_i and out_ready_i with SRAM non-empty -> in_ready_o toggles 1/0 each cycle; no words lost or reordered over 100 words.
REQ-023 Clear with 3 words held and a read in flight -> next cycle level_o=0, out_valid_o=0; the flushed read data never appears.
REQ-024 rst_ni low for one cycle mid-stream -> REQ-017 values next cycle; the first new push emerges unaltered.
